// File: rtl/fp_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_unit_arbiter
// Description : Round-robin arbiter sharing one floating-point unit between
//               two requesters. Issues one operation at a time, waits for the
//               unit's completion strobe (with a timeout that returns a
//               quiet NaN), then pulses done to the owning requester.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_unit_arbiter #(
    parameter int unsigned TIMEOUT    = 64,
    parameter logic [31:0] ERR_RESULT = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        reset,
    // requester 0
    input  logic        req0_valid,
    input  logic [31:0] req0_dataa,
    input  logic [31:0] req0_datab,
    output logic        req0_ready,
    output logic        req0_done,
    output logic [31:0] req0_result,
    output logic        req0_err,
    // requester 1
    input  logic        req1_valid,
    input  logic [31:0] req1_dataa,
    input  logic [31:0] req1_datab,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [31:0] req1_result,
    output logic        req1_err,
    // shared FP unit
    output logic        fp_start,
    output logic [31:0] fp_dataa,
    output logic [31:0] fp_datab,
    input  logic        fp_done,
    input  logic [31:0] fp_result,
    // status
    output logic        busy
);

    localparam int unsigned        c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 ptr_q, ptr_d;       // preferred requester on contention
    logic                 owner_q, owner_d;   // requester of the operation in flight
    logic [31:0]          dataa_q, dataa_d;
    logic [31:0]          datab_q, datab_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [31:0]          res0_q, res0_d;
    logic [31:0]          res1_q, res1_d;
    logic                 err0_q, err0_d;
    logic                 err1_q, err1_d;

    logic                 w_grant_valid;
    logic                 w_grant_id;

    // Pick the winner among valid requesters; the pointer breaks ties.
    always_comb begin
        w_grant_valid = req0_valid | req1_valid;
        w_grant_id    = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        req0_ready    = (state_q == S_IDLE) && w_grant_valid && !w_grant_id;
        req1_ready    = (state_q == S_IDLE) && w_grant_valid &&  w_grant_id;
    end

    // Next-state and datapath update for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        dataa_d = dataa_q;
        datab_d = datab_q;
        cnt_d   = cnt_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        err0_d  = err0_q;
        err1_d  = err1_q;

        case (state_q)
            S_IDLE: begin
                if (w_grant_valid) begin
                    owner_d = w_grant_id;
                    ptr_d   = ~w_grant_id;
                    dataa_d = w_grant_id ? req1_dataa : req0_dataa;
                    datab_d = w_grant_id ? req1_datab : req0_datab;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the timeout boundary still counts as success.
                if (fp_done) begin
                    if (owner_q) begin
                        res1_d = fp_result;
                        err1_d = 1'b0;
                    end else begin
                        res0_d = fp_result;
                        err0_d = 1'b0;
                    end
                    state_d = S_RESP;
                end else if (cnt_q == c_cnt_last) begin
                    if (owner_q) begin
                        res1_d = ERR_RESULT;
                        err1_d = 1'b1;
                    end else begin
                        res0_d = ERR_RESULT;
                        err0_d = 1'b1;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            dataa_q <= '0;
            datab_q <= '0;
            cnt_q   <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            dataa_q <= dataa_d;
            datab_q <= datab_d;
            cnt_q   <= cnt_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        fp_start    = (state_q == S_ISSUE);
        busy        = (state_q != S_IDLE);
        req0_done   = (state_q == S_RESP) && !owner_q;
        req1_done   = (state_q == S_RESP) &&  owner_q;
        fp_dataa    = dataa_q;
        fp_datab    = datab_q;
        req0_result = res0_q;
        req1_result = res1_q;
        req0_err    = err0_q;
        req1_err    = err1_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_unit_arbiter
// Description : Directed self-checking bench for fp_unit_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_unit_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_dataa, req0_datab, req1_dataa, req1_datab;
    logic        req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err;
    logic [31:0] req0_result, req1_result;
    logic        fp_start, fp_done, busy;
    logic [31:0] fp_dataa, fp_datab, fp_result;

    int total = 0;
    int bad   = 0;

    fp_unit_arbiter #(
        .TIMEOUT    (64),
        .ERR_RESULT (32'h7FC00000)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_dataa  (req0_dataa),
        .req0_datab  (req0_datab),
        .req0_ready  (req0_ready),
        .req0_done   (req0_done),
        .req0_result (req0_result),
        .req0_err    (req0_err),
        .req1_valid  (req1_valid),
        .req1_dataa  (req1_dataa),
        .req1_datab  (req1_datab),
        .req1_ready  (req1_ready),
        .req1_done   (req1_done),
        .req1_result (req1_result),
        .req1_err    (req1_err),
        .fp_start    (fp_start),
        .fp_dataa    (fp_dataa),
        .fp_datab    (fp_datab),
        .fp_done     (fp_done),
        .fp_result   (fp_result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one operation starting in an IDLE cycle with inputs already applied.
    // The unit answers 'lat' cycles after fp_start; the owner drops valid once accepted.
    task automatic do_op(input int own, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] res, input int lat);
        chk("ready0", req0_ready, own == 0);
        chk("ready1", req1_ready, own == 1);
        tick();
        if (own == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        chk("fp_start", fp_start, 1);
        chk("busy_issue", busy, 1);
        chk("fp_dataa", fp_dataa, ea);
        chk("fp_datab", fp_datab, eb);
        for (int i = 0; i < lat; i++) begin
            tick();
            if (i == 0) chk("start_one_cycle", fp_start, 0);
        end
        fp_done   = 1'b1;
        fp_result = res;
        tick();
        fp_done   = 1'b0;
        fp_result = 32'h0;
        chk("done0", req0_done, own == 0);
        chk("done1", req1_done, own == 1);
        chk("result", (own == 1) ? req1_result : req0_result, res);
        chk("err", (own == 1) ? req1_err : req0_err, 0);
        tick();
        chk("done0_after", req0_done, 0);
        chk("done1_after", req1_done, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        int early;
        reset      = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_dataa = '0; req0_datab = '0; req1_dataa = '0; req1_datab = '0;
        fp_done    = 1'b0; fp_result = '0;
        repeat (3) tick();

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_start", fp_start, 0);
        chk("rst_done0", req0_done, 0);
        chk("rst_res0", req0_result, 0);
        chk("rst_fpa", fp_dataa, 0);
        reset = 1'b0;
        tick();

        // stray fp_done in IDLE with no request
        fp_done = 1'b1; fp_result = 32'hDEADBEEF;
        tick();
        fp_done = 1'b0; fp_result = 32'h0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_done0", req0_done, 0);
        chk("idle_done_res0", req0_result, 0);
        tick();
        chk("idle_done_busy2", busy, 0);

        // single requester, unit answers two cycles after start
        req0_valid = 1'b1; req0_dataa = 32'h437F0000; req0_datab = 32'h43000000;
        #1;
        do_op(0, 32'h437F0000, 32'h43000000, 32'h43BF8000, 2);
        chk("r0_hold", req0_result, 32'h43BF8000);

        // reset clears results and the round-robin pointer
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_res0", req0_result, 0);

        // both valid together after reset: req0 first, then req1
        req0_valid = 1'b1; req0_dataa = 32'h3F800000; req0_datab = 32'h40000000;
        req1_valid = 1'b1; req1_dataa = 32'h40400000; req1_datab = 32'h40800000;
        #1;
        do_op(0, 32'h3F800000, 32'h40000000, 32'h40400000, 1);
        do_op(1, 32'h40400000, 32'h40800000, 32'h40E00000, 3);
        chk("nonowner_res0", req0_result, 32'h40400000);

        // req1 held valid, req0 arrives after req1 accepted -> req0 next
        req1_valid = 1'b1; req1_dataa = 32'h41000000; req1_datab = 32'h41100000;
        #1;
        chk("rr_ready1", req1_ready, 1);
        chk("rr_ready0", req0_ready, 0);
        tick();
        req0_valid = 1'b1; req0_dataa = 32'h41200000; req0_datab = 32'h41300000;
        #1;
        chk("rr_issue_ready0", req0_ready, 0);
        chk("rr_issue_fpa", fp_dataa, 32'h41000000);
        tick();
        fp_done = 1'b1; fp_result = 32'h42000000;
        tick();
        fp_done = 1'b0; fp_result = 32'h0;
        chk("rr_done1", req1_done, 1);
        chk("rr_res1", req1_result, 32'h42000000);
        chk("rr_resp_ready1", req1_ready, 0);
        tick();
        chk("rr_fpa_hold", fp_dataa, 32'h41000000);
        do_op(0, 32'h41200000, 32'h41300000, 32'h42100000, 1);
        do_op(1, 32'h41000000, 32'h41100000, 32'h42200000, 1);

        // timeout: fp_done only during ISSUE (ignored), never in WAIT
        req0_valid = 1'b1; req0_dataa = 32'h11111111; req0_datab = 32'h22222222;
        #1;
        tick();
        req0_valid = 1'b0;
        chk("to_start", fp_start, 1);
        fp_done = 1'b1; fp_result = 32'h12345678;
        tick();
        fp_done = 1'b0; fp_result = 32'h0;
        early = 0;
        for (int i = 1; i < 64; i++) begin
            if (req0_done) early++;
            tick();
        end
        if (req0_done) early++;
        chk("to_no_early_done", early, 0);
        tick();
        chk("to_done", req0_done, 1);
        chk("to_res", req0_result, 32'h7FC00000);
        chk("to_err", req0_err, 1);
        tick();
        chk("to_busy", busy, 0);
        chk("to_err_hold", req0_err, 1);

        // fp_done exactly on the timeout boundary wins
        req1_valid = 1'b1; req1_dataa = 32'h33333333; req1_datab = 32'h44444444;
        #1;
        chk("bd_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        repeat (64) tick();
        fp_done = 1'b1; fp_result = 32'h55555555;
        tick();
        fp_done = 1'b0; fp_result = 32'h0;
        chk("bd_done1", req1_done, 1);
        chk("bd_res1", req1_result, 32'h55555555);
        chk("bd_err1", req1_err, 0);
        tick();

        // reset mid-WAIT, late fp_done after release
        req0_valid = 1'b1; req0_dataa = 32'h66666666; req0_datab = 32'h77777777;
        #1;
        tick();
        req0_valid = 1'b0;
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("mr_busy_async", busy, 0);
        chk("mr_fpa", fp_dataa, 0);
        chk("mr_res1", req1_result, 0);
        chk("mr_err0", req0_err, 0);
        tick();
        reset = 1'b0;
        fp_done = 1'b1; fp_result = 32'h88888888;
        tick();
        fp_done = 1'b0; fp_result = 32'h0;
        chk("mr_late_done0", req0_done, 0);
        chk("mr_late_busy", busy, 0);
        chk("mr_late_res0", req0_result, 0);
        tick();
        chk("mr_late_done0b", req0_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_unit_arbiter.md
FP_UNIT_ARBITER -- requirements
Module: fp_unit_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum WAIT cycles before the block aborts an operation.
REQ-002 Parameter ERR_RESULT, default 32'h7FC00000: quiet-NaN result returned on timeout.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  in  1  requester N has an operation pending.
REQ-006 req0_dataa / req1_dataa  in  32  IEEE-754 single operand A of requester N.
REQ-007 req0_datab / req1_datab  in  32  IEEE-754 single operand B of requester N.
REQ-008 req0_ready / req1_ready  out  1  grant; operands are accepted when valid and ready are both high.
REQ-009 req0_done / req1_done  out  1  one-cycle completion pulse to requester N.
REQ-010 req0_result / req1_result  out  32  last result for requester N, held until that requester's next done.
REQ-011 req0_err / req1_err  out  1  timeout flag, valid with done, held with result.
REQ-012 fp_start  out  1  one-cycle start pulse to the shared FP unit.
REQ-013 fp_dataa / fp_datab  out  32  latched operands; stable from ISSUE through end of WAIT.
REQ-014 fp_done  in  1  shared unit completion strobe.
REQ-015 fp_result  in  32  shared unit result, valid when fp_done is high.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-018 IDLE: reqN_ready is combinational and high only for the granted requester; at most one ready is high in any cycle.
REQ-019 Grant: a single valid requester wins; if both are valid, the requester indicated by the round-robin pointer wins.
REQ-020 Acceptance: latch dataa, datab and owner id; pointer moves to the non-owner; next state is ISSUE.
REQ-021 ISSUE: fp_start=1 for exactly one cycle; clear the WAIT counter; next state is WAIT.
REQ-022 WAIT: fp_done=1 captures fp_result into the owner's result register, sets err=0, and moves to RESP.
REQ-023 WAIT with no fp_done: the counter increments; when it reaches TIMEOUT-1, load ERR_RESULT, set err=1, and move to RESP.
REQ-024 fp_done in the same cycle as the timeout boundary: fp_done wins (err=0).
REQ-025 fp_done during IDLE, ISSUE or RESP is ignored.
REQ-026 RESP: the owner's done=1 for one cycle; next state is IDLE; the non-owner's outputs are unchanged.
REQ-027 Latency: acceptance edge E gives fp_start in cycle E+1; fp_done seen in cycle D gives done in cycle D+1; minimum accept-to-done is 3 cycles.
REQ-028 A requester holding valid through its own done may be re-granted no earlier than the IDLE cycle after RESP; if the other requester is also valid, the other one is granted first.
REQ-029 reqN_valid falling while not granted SHALL have no effect; there is no queuing.
REQ-030 fp_dataa and fp_datab SHALL not change from the acceptance edge until the next acceptance.

Reset
REQ-031 reset SHALL force IDLE immediately, regardless of the clock.
REQ-032 reset SHALL clear the pointer to requester 0.
REQ-033 reset SHALL force all done, err, fp_start and busy outputs to 0.
REQ-034 reset SHALL clear all result registers and fp operands to 0.
REQ-035 Reset during WAIT abandons the operation: no done pulse is emitted, and a late fp_done after release is ignored.

Verification
REQ-036 req0 only, 0x437F0000 (255.0) and 0x43000000 (128.0); unit returns 0x43BF8000 two cycles after fp_start -> req0_done 1 cycle later, req0_result=0x43BF8000, req0_err=0.
REQ-037 Both valid in the same cycle after reset -> req0 served first, then req1; fp_start pulses in that order; each done pulse goes only to its owner.
REQ-038 req1 valid continuously, req0 valid only after req1 is accepted -> req0 granted next (round-robin), not req1.
REQ-039 fp_done never asserted, TIMEOUT=64 -> done 65 cycles after fp_start, result=0x7FC00000, err=1, busy low in the following cycle.
REQ-040 reset asserted mid-WAIT, then fp_done asserted after release -> no done pulse, busy=0, all outputs zero.
REQ-041 fp_done pulsed during IDLE with no request -> no state change and no done pulse.
